// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// reset_sequencer
//   Power-on / trigger reset sequencer. After reset (or a restart trigger)
//   every channel is held in reset for CYCLES clocks. The channels are then
//   released one at a time, STAGE_GAP clocks apart, bit 0 first. ready_o
//   rises together with the last release. A debounced button, a software
//   request or a watchdog timeout restarts the whole sequence and records
//   the cause.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   btn_i       asynchronous reset button, active high (synchronized here)
//   sw_req_i    synchronous software restart request
//   wdt_en_i    watchdog enable level
//   wdt_kick_i  watchdog refresh pulse
//   reset_o     per-channel active-high reset, bit 0 released first
//   ready_o     high only while all channels are released (RUN)
//   cause_o     last restart cause: 00 power-on, 01 button, 10 software,
//               11 watchdog
//
// state | meaning
// ------+---------------------------------------------------------------
// HOLD  | all channels in reset, hold counter running, triggers ignored
// STAGE | channels being released one per STAGE_GAP clocks
// RUN   | all channels released, ready_o high, watchdog may run
module reset_sequencer #(
  parameter int CYCLES     = 20,
  parameter int CHANNELS   = 2,
  parameter int STAGE_GAP  = 4,
  parameter int DEBOUNCE   = 16,
  parameter int WDT_CYCLES = 1048576
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_i,
  input  logic                sw_req_i,
  input  logic                wdt_en_i,
  input  logic                wdt_kick_i,
  output logic [CHANNELS-1:0] reset_o,
  output logic                ready_o,
  output logic [1:0]          cause_o
);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("reset_sequencer: CYCLES must be >= 1");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("reset_sequencer: CHANNELS must be in 1..8");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("reset_sequencer: DEBOUNCE must be >= 1");
  end
  if (WDT_CYCLES < 2) begin : g_bad_wdt
    $error("reset_sequencer: WDT_CYCLES must be >= 2");
  end

  localparam int HOLD_W = $clog2(CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam int WDT_W  = $clog2(WDT_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEBOUNCE);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
  localparam logic [WDT_W-1:0]  WDT_ONE   = WDT_W'(1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [IDX_W-1:0]    stage_idx, idx_nxt;
  logic [CHANNELS-1:0] rst_nxt;
  logic                ready_nxt;
  logic [1:0]          cause_nxt;

  logic                btn_meta, btn_sync;
  logic [DEB_W-1:0]    deb_cnt;
  logic                btn_evt;
  logic [WDT_W-1:0]    wdt_cnt;
  logic                wdt_run;
  logic                wdt_exp;
  logic                trig;
  logic [1:0]          trig_cause;

  // Button synchronizer and debounce. The counter saturates at DEBOUNCE so
  // the event fires exactly once per high period, whatever the FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_meta <= btn_i;
      btn_sync <= btn_meta;
      if (!btn_sync) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_FULL) begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  // Fires on the cycle in which the synchronized level completes its
  // DEBOUNCE-th consecutive high cycle.
  assign btn_evt = btn_sync && (deb_cnt == DEB_LAST);

  // Watchdog: only ticks while running and enabled; anything else clears it.
  assign wdt_run = (state == RUN) && wdt_en_i;
  assign wdt_exp = wdt_run && !wdt_kick_i && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt <= '0;
    end else if (!wdt_run || wdt_kick_i) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_ONE;
    end
  end

  assign trig = btn_evt || sw_req_i || wdt_exp;

  always_comb begin
    trig_cause = 2'b01;
    if (wdt_exp) begin
      trig_cause = 2'b11;
    end else if (sw_req_i) begin
      trig_cause = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage_idx <= '0;
      reset_o   <= '1;
      ready_o   <= 1'b0;
      cause_o   <= 2'b00;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      stage_idx <= idx_nxt;
      reset_o   <= rst_nxt;
      ready_o   <= ready_nxt;
      cause_o   <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    idx_nxt   = stage_idx;
    rst_nxt   = reset_o;
    ready_nxt = ready_o;
    cause_nxt = cause_o;

    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          rst_nxt[0] = 1'b0;
          gap_nxt    = GAP_ONE;
          idx_nxt    = IDX_ONE;
          if (CHANNELS == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = STAGE;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_ONE;
        end
      end
      STAGE: begin
        if (gap_cnt == GAP_LAST) begin
          rst_nxt[stage_idx] = 1'b0;
          gap_nxt            = GAP_ONE;
          idx_nxt            = stage_idx + IDX_ONE;
          if (stage_idx == IDX_LAST) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt + GAP_ONE;
        end
      end
      RUN: begin
      end
      default: begin
        state_nxt = HOLD;
        hold_nxt  = '0;
        rst_nxt   = '1;
        ready_nxt = 1'b0;
      end
    endcase

    // Restart overrides normal progression. The entry edge itself counts as
    // the first held cycle, so the counter restarts at one; that keeps the
    // release CYCLES edges after entry, matching the power-on case where
    // the first edge out of reset is cycle 0.
    if (trig && (state == STAGE || state == RUN)) begin
      state_nxt = HOLD;
      hold_nxt  = HOLD_ONE;
      rst_nxt   = '1;
      ready_nxt = 1'b0;
      cause_nxt = trig_cause;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int CYC      = 20;
  localparam int CH       = 3;
  localparam int GAP      = 4;
  localparam int DEB      = 16;
  localparam int WDT      = 64;
  localparam int LAST_REL = CYC + (CH - 1) * GAP;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          btn = 1'b0;
  logic          sw_req = 1'b0;
  logic          wdt_en = 1'b0;
  logic          wdt_kick = 1'b0;
  logic [CH-1:0] reset_o;
  logic          ready_o;
  logic [1:0]    cause_o;

  reset_sequencer #(
    .CYCLES    (CYC),
    .CHANNELS  (CH),
    .STAGE_GAP (GAP),
    .DEBOUNCE  (DEB),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (btn),
    .sw_req_i  (sw_req),
    .wdt_en_i  (wdt_en),
    .wdt_kick_i(wdt_kick),
    .reset_o   (reset_o),
    .ready_o   (ready_o),
    .cause_o   (cause_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time since the current sequence started, plus streak
  // lengths for the button level and the watchdog condition.
  int m_el;
  int m_cause;
  int m_bstreak;
  int m_wstreak;
  int bhist[$];

  typedef struct {
    int            cyc;
    logic [CH-1:0] rst;
    logic          rdy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_rst_of(input int el);
    int r = 0;
    for (int k = 0; k < CH; k++)
      if (el < CYC + k * GAP) r |= (1 << k);
    return r;
  endfunction

  function automatic int packed_out();
    return int'({reset_o, ready_o, cause_o});
  endfunction

  function automatic int model_out();
    return (exp_rst_of(m_el) << 3) | ((m_el >= LAST_REL) ? 4 : 0) | m_cause;
  endfunction

  task automatic model_reset();
    m_el      = -1;
    m_cause   = 0;
    m_bstreak = 0;
    m_wstreak = 0;
    bhist     = '{0, 0};
  endtask

  task automatic model_edge(input logic b, input logic s, input logic e, input logic k);
    bit in_hold, in_run, evt, expd, wc;
    int sb;
    in_hold = (m_el < CYC);
    in_run  = (m_el >= LAST_REL);
    sb = bhist.pop_front();
    bhist.push_back(int'(b));
    if (sb != 0) m_bstreak = (m_bstreak > DEB) ? m_bstreak : m_bstreak + 1;
    else m_bstreak = 0;
    evt = (m_bstreak == DEB);
    wc = in_run && e && !k;
    m_wstreak = wc ? m_wstreak + 1 : 0;
    expd = (m_wstreak == WDT);
    if (!in_hold && (evt || s || expd)) begin
      m_cause = expd ? 3 : (s ? 2 : 1);
      m_el = 0;
    end else if (m_el < 100000) begin
      m_el++;
    end
  endtask

  task automatic step(input logic b, input logic s, input logic e, input logic k);
    btn = b; sw_req = s; wdt_en = e; wdt_kick = k;
    @(posedge clk);
    model_edge(b, s, e, k);
    #1;
    chk("model", packed_out(), model_out());
  endtask

  task automatic run_table(input string tag, input int start);
    int pos = start;
    for (int i = 0; i < 8; i++) begin
      while (pos < tbl[i].cyc) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        pos++;
      end
      chk($sformatf("%s_rst_c%0d", tag, tbl[i].cyc), int'(reset_o), int'(tbl[i].rst));
      chk($sformatf("%s_rdy_c%0d", tag, tbl[i].cyc), int'(ready_o), int'(tbl[i].rdy));
    end
  endtask

  task automatic async_pulse();
    #2 reset = 1'b0;
    #1 chk("async_reset", packed_out(), 56);
    model_reset();
    btn = 1'b0; sw_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    @(posedge clk);
    #1 chk("async_reset_held", packed_out(), 56);
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int drops;
    logic prev;
    logic rb, rs, re, rk;

    tbl[0] = '{0,  3'b111, 1'b0};
    tbl[1] = '{19, 3'b111, 1'b0};
    tbl[2] = '{20, 3'b110, 1'b0};
    tbl[3] = '{23, 3'b110, 1'b0};
    tbl[4] = '{24, 3'b100, 1'b0};
    tbl[5] = '{27, 3'b100, 1'b0};
    tbl[6] = '{28, 3'b000, 1'b1};
    tbl[7] = '{40, 3'b000, 1'b1};

    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("por_state", packed_out(), 56);
    @(negedge clk) reset = 1'b1;
    run_table("por", -1);
    chk("por_cause", int'(cause_o), 0);

    // Software restart from RUN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sw_entry", packed_out(), 58);
    run_table("sw", 0);

    // Short button press: no effect
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("btn_short_rdy", int'(ready_o), 1);
    chk("btn_short_cause", int'(cause_o), 2);

    // Long button press: exactly one restart
    drops = 0;
    prev = ready_o;
    for (int i = 0; i < 260; i++) begin
      step((i < 200), 1'b0, 1'b0, 1'b0);
      if (prev && !ready_o) drops++;
      prev = ready_o;
    end
    chk("btn_long_restarts", drops, 1);
    chk("btn_long_cause", int'(cause_o), 1);
    chk("btn_long_rdy", int'(ready_o), 1);

    // Watchdog expiry 64 cycles after RUN entry
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!ready_o && n < 100) begin step(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    chk("wdt_run_entry", n, LAST_REL);
    n = 0;
    while (ready_o && n < 200) begin step(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    chk("wdt_expiry_delay", n, WDT);
    chk("wdt_cause", int'(cause_o), 3);

    // Regular kicks keep the system running
    n = 0;
    while (!ready_o && n < 100) begin step(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    drops = 0;
    prev = ready_o;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b0, 1'b1, ((i % 50) == 49));
      if (prev && !ready_o) drops++;
      prev = ready_o;
    end
    chk("wdt_kick_restarts", drops, 0);
    chk("wdt_kick_rdy", int'(ready_o), 1);

    // Software request on the same edge as watchdog expiry
    repeat (63) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("coincident_pre_rdy", int'(ready_o), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("coincident_entry", packed_out(), 59);

    // Software requests during HOLD are ignored
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hold_sw_cause", int'(cause_o), 3);
    run_table("hold_sw", 5);

    // Asynchronous reset in the middle of STAGE
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (22) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_stage_rst", int'(reset_o), 3'b110);
    async_pulse();
    run_table("rerun", -1);
    chk("rerun_cause", int'(cause_o), 0);

    // Randomized traffic against the model
    rb = 1'b0; re = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) rb = ~rb;
      if ($urandom_range(199) == 0) re = ~re;
      rs = ($urandom_range(149) == 0);
      rk = ($urandom_range(89) == 0);
      step(rb, rs, re, rk);
      if ($urandom_range(999) == 0) begin
        async_pulse();
        rb = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
